// File: rtl/wallace_mult_pipe_if.sv
// wallace_mult_pipe_if: handshake bundle for the pipelined Wallace-tree multiplier.
//   Operand side : in_valid, in_ready, in_a, in_b, in_signed, in_tag
//   Result side  : out_valid, out_ready, out_product, out_tag
//   master : operand producer / result consumer
//   slave  : the multiplier
interface wallace_mult_pipe_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned TAG_W = 4
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_a;
   logic [WIDTH-1:0]     in_b;
   logic                 in_signed;
   logic [TAG_W-1:0]     in_tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out_product;
   logic [TAG_W-1:0]     out_tag;

   modport master (
      output in_valid, in_a, in_b, in_signed, in_tag, out_ready,
      input  in_ready, out_valid, out_product, out_tag
   );

   modport slave (
      input  in_valid, in_a, in_b, in_signed, in_tag, out_ready,
      output in_ready, out_valid, out_product, out_tag
   );
endinterface

// File: rtl/wallace_mult_pipe.sv
// wallace_mult_pipe: three-stage WIDTH x WIDTH multiplier, signed/unsigned per transaction.
//   S1 captures operands, S2 builds partial products and reduces them with a Wallace tree
//   of full/half adders down to a sum row and a carry row, S3 adds the two rows.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : wallace_mult_pipe_if.slave (valid/ready operand input, valid/ready result output)
// The whole pipe freezes while a result is held (out_valid & ~out_ready); bubbles are kept.
module wallace_mult_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   wallace_mult_pipe_if.slave bus
);

   localparam int W      = int'(WIDTH);
   localparam int PW     = 2 * W;
   // Tallest initial column is W bits (column W-1, or column W with its constant).
   localparam int MAXH   = W + 2;
   // Enough layers for a 33-bit column; extra layers are skipped once reduction is done.
   localparam int LAYERS = 10;

   logic             stall;
   logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d;
   logic             sgn_q, sgn_d;
   logic [TAG_W-1:0] tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d;
   logic [PW-1:0]    sum_q, sum_d, carry_q, carry_d, prod_q, prod_d;

   // Reduction working storage: one bit-vector plus live height per column.
   logic [MAXH-1:0]  col [PW];
   logic [MAXH-1:0]  nxt [PW];
   int               h   [PW];
   int               nh  [PW];
   int               base;
   logic             busy, pp, x, y, z, s, c;
   logic [PW-1:0]    sum_row, carry_row;

   assign stall           = v3_q & ~bus.out_ready;
   assign bus.in_ready    = ~stall;
   assign bus.out_valid   = v3_q;
   assign bus.out_product = prod_q;
   assign bus.out_tag     = tag3_q;

   // Wallace reduction of the S1 operands. The signed-mode constants are placed as
   // sgn_q bits so the tree shape is identical in both modes.
   always_comb begin
      busy = 1'b0;
      base = 0;
      pp   = 1'b0;
      x    = 1'b0;
      y    = 1'b0;
      z    = 1'b0;
      s    = 1'b0;
      c    = 1'b0;
      for (int k = 0; k < PW; k++) begin
         col[k] = '0;
         nxt[k] = '0;
         h[k]   = 0;
         nh[k]  = 0;
      end
      for (int i = 0; i < W; i++) begin
         for (int j = 0; j < W; j++) begin
            pp = a_q[i] & b_q[j];
            // Baugh-Wooley: invert sign-row/column terms, but not the a[W-1]&b[W-1] corner.
            if (sgn_q && ((i == W - 1) != (j == W - 1))) pp = ~pp;
            col[i+j][h[i+j]] = pp;
            h[i+j] = h[i+j] + 1;
         end
      end
      col[W][h[W]] = sgn_q;
      h[W] = h[W] + 1;
      col[PW-1][h[PW-1]] = sgn_q;
      h[PW-1] = h[PW-1] + 1;

      for (int l = 0; l < LAYERS; l++) begin
         busy = 1'b0;
         for (int k = 0; k < PW; k++) begin
            if (h[k] > 2) busy = 1'b1;
            nxt[k] = '0;
            nh[k]  = 0;
         end
         if (busy) begin
            for (int k = 0; k < PW; k++) begin
               for (int g = 0; g < MAXH / 3; g++) begin
                  if (3 * g + 3 <= h[k]) begin
                     x = col[k][3*g];
                     y = col[k][3*g+1];
                     z = col[k][3*g+2];
                     s = x ^ y ^ z;
                     c = (x & y) | (x & z) | (y & z);
                     nxt[k][nh[k]] = s;
                     nh[k] = nh[k] + 1;
                     // Carries out of the top column fall off: product is mod 2^(2W).
                     if (k + 1 < PW) begin
                        nxt[k+1][nh[k+1]] = c;
                        nh[k+1] = nh[k+1] + 1;
                     end
                  end
               end
               base = (h[k] / 3) * 3;
               if (h[k] - base == 2) begin
                  x = col[k][base];
                  y = col[k][base+1];
                  nxt[k][nh[k]] = x ^ y;
                  nh[k] = nh[k] + 1;
                  if (k + 1 < PW) begin
                     nxt[k+1][nh[k+1]] = x & y;
                     nh[k+1] = nh[k+1] + 1;
                  end
               end else if (h[k] - base == 1) begin
                  nxt[k][nh[k]] = col[k][base];
                  nh[k] = nh[k] + 1;
               end
            end
            for (int k = 0; k < PW; k++) begin
               col[k] = nxt[k];
               h[k]   = nh[k];
            end
         end
      end

      for (int k = 0; k < PW; k++) begin
         sum_row[k]   = col[k][0];
         carry_row[k] = col[k][1];
      end
   end

   // Stage advance; data registers only load behind a valid so outputs never change on bubbles.
   always_comb begin
      v1_d    = v1_q;
      v2_d    = v2_q;
      v3_d    = v3_q;
      a_d     = a_q;
      b_d     = b_q;
      sgn_d   = sgn_q;
      tag1_d  = tag1_q;
      tag2_d  = tag2_q;
      tag3_d  = tag3_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      prod_d  = prod_q;
      if (!stall) begin
         v1_d = bus.in_valid;
         if (bus.in_valid) begin
            a_d    = bus.in_a;
            b_d    = bus.in_b;
            sgn_d  = bus.in_signed;
            tag1_d = bus.in_tag;
         end
         v2_d = v1_q;
         if (v1_q) begin
            sum_d   = sum_row;
            carry_d = carry_row;
            tag2_d  = tag1_q;
         end
         v3_d = v2_q;
         if (v2_q) begin
            prod_d = sum_q + carry_q;
            tag3_d = tag2_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q    <= 1'b0;
         v2_q    <= 1'b0;
         v3_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sgn_q   <= 1'b0;
         tag1_q  <= '0;
         tag2_q  <= '0;
         tag3_q  <= '0;
         sum_q   <= '0;
         carry_q <= '0;
         prod_q  <= '0;
      end else begin
         v1_q    <= v1_d;
         v2_q    <= v2_d;
         v3_q    <= v3_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sgn_q   <= sgn_d;
         tag1_q  <= tag1_d;
         tag2_q  <= tag2_d;
         tag3_q  <= tag3_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         prod_q  <= prod_d;
      end
   end

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// tb_wallace_mult_pipe: scoreboard bench for wallace_mult_pipe at WIDTH=8, TAG_W=4.
// The stimulus process pushes the expected product/tag at accept time; an independent
// monitor compares every presented result against the queue head on the falling edge.
module tb_wallace_mult_pipe;

   localparam int unsigned W  = 8;
   localparam int unsigned TW = 4;
   localparam int unsigned P  = 2 * W;

   typedef struct packed {
      logic [P-1:0]  p;
      logic [TW-1:0] t;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wallace_mult_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

   wallace_mult_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   exp_t q[$];
   int   n_chk    = 0;
   int   n_fail   = 0;
   int   n_acc    = 0;
   int   n_cons   = 0;
   int   run      = 0;
   int   max_run  = 0;
   int   rdy_mode = 0;
   int   rdy_cnt  = 0;
   int   lat;
   logic [P-1:0] bp_exp [8] = '{16'd2, 16'd6, 16'd12, 16'd20, 16'd30, 16'd42, 16'd56, 16'd72};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [P-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic sg);
      logic [P-1:0] ea, eb;
      ea = sg ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
      eb = sg ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
      return ea * eb;
   endfunction

   // Called and returns at posedge+1; an accepted op leaves in_valid low again.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                       input logic [TW-1:0] tag, input logic [P-1:0] expv);
      bit done = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_signed = sg;
      bus.in_tag    = tag;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            q.push_back('{p: expv, t: tag});
            n_acc++;
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!done) check("send_timeout", {63'd0, done}, 64'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Accept edge counts as edge 1; returns number of edges up to the one raising out_valid.
   task automatic wait_valid(output int n);
      n = 1;
      while (n < 20) begin
         @(negedge clk);
         if (bus.out_valid) break;
         @(posedge clk);
         #1;
         n++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_empty", 64'(q.size()), 64'd0);
   endtask

   // Consumer: out_ready policy selected by rdy_mode.
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            1: begin
               bus.out_ready = (rdy_cnt % 3 == 0);
               rdy_cnt++;
            end
            2:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b1;
         endcase
      end
   end

   // Monitor / scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
            check("rst_out_product", 64'(bus.out_product), 64'd0);
            run = 0;
         end else begin
            check("in_ready", {63'd0, bus.in_ready},
                  {63'd0, !(bus.out_valid && !bus.out_ready)});
            if (bus.out_valid) begin
               if (q.size() == 0) begin
                  check("unexpected_out_valid", {63'd0, bus.out_valid}, 64'd0);
               end else begin
                  check("out_product", 64'(bus.out_product), 64'(q[0].p));
                  check("out_tag", 64'(bus.out_tag), 64'(q[0].t));
                  if (bus.out_ready) begin
                     void'(q.pop_front());
                     n_cons++;
                  end
               end
            end
            if (bus.out_valid && bus.out_ready) run++;
            else run = 0;
            if (run > max_run) max_run = run;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0]  ra, rb;
      logic          rs;
      logic [TW-1:0] rt;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_signed = 1'b0;
      bus.in_tag    = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_tag", 64'(bus.out_tag), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_rst", {63'd0, bus.in_ready}, 64'd1);
      @(posedge clk);
      #1;

      // Unsigned corner 0xFF * 0xFF, latency from accept.
      send(8'hFF, 8'hFF, 1'b0, 4'hA, 16'hFE01);
      wait_valid(lat);
      check("latency_unsigned", 64'(lat), 64'd3);
      idle(2);

      // Signed sweep back-to-back: results must come out on consecutive cycles.
      max_run = 0;
      send(8'h80, 8'h80, 1'b1, 4'h1, 16'h4000);
      send(8'hFF, 8'h01, 1'b1, 4'h2, 16'hFFFF);
      send(8'h7F, 8'h80, 1'b1, 4'h3, 16'hC080);
      send(8'h00, 8'hFB, 1'b1, 4'h4, 16'h0000);
      idle(6);
      check("signed_no_bubble_run", 64'(max_run), 64'd4);

      // Mode switch with no bubble.
      max_run = 0;
      send(8'h80, 8'h02, 1'b0, 4'h5, 16'h0100);
      send(8'h80, 8'h02, 1'b1, 4'h6, 16'hFF00);
      idle(6);
      check("mixed_no_bubble_run", 64'(max_run), 64'd2);

      // Backpressure with out_ready pattern 1,0,0,...
      rdy_mode = 1;
      rdy_cnt  = 0;
      for (int t = 0; t < 8; t++) begin
         send(W'(t + 1), W'(t + 2), 1'b0, TW'(t), bp_exp[t]);
      end
      drain();
      rdy_mode = 0;
      idle(2);

      // Reset while three ops are in flight: all of them must vanish.
      send(8'h05, 8'h05, 1'b1, 4'h1, 16'd25);
      send(8'h03, 8'h07, 1'b0, 4'h2, 16'd21);
      send(8'hF0, 8'hF0, 1'b0, 4'h3, 16'hE100);
      rst = 1'b1;
      q.delete();
      n_acc  = 0;
      n_cons = 0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(5);
      send(8'd12, 8'd11, 1'b0, 4'h9, 16'd132);
      wait_valid(lat);
      check("latency_after_reset", 64'(lat), 64'd3);
      idle(2);

      // Random operands, mode, input gaps and output backpressure.
      rdy_mode = 2;
      repeat (1500) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rs = 1'($urandom_range(0, 1));
         rt = TW'($urandom);
         if ($urandom_range(0, 3) == 0) idle(1);
         send(ra, rb, rs, rt, model(ra, rb, rs));
      end
      drain();
      rdy_mode = 0;
      idle(3);
      check("accepted_eq_consumed", 64'(n_cons), 64'(n_acc));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/wallace_mult_pipe.md
Name: wallace_mult_pipe

Overview:
Parametrised, pipelined Wallace-tree multiplier: WIDTH x WIDTH operands, 2*WIDTH-bit product, selectable signed/unsigned mode per transaction.
- Partial products are reduced with half/full-adder CSA layers to two rows, then resolved by a final carry-propagate adder.
- Three register stages with valid/ready handshake, full-rate throughput and backpressure.
- Replaces the fixed 4-bit combinational multiplier in datapaths that need wider operands, signed arithmetic and timing closure.

Parameters:
WIDTH, 8, operand width in bits; legal range 4..32.
TAG_W, 4, width of the sideband tag carried alongside each operation; minimum 1.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair present
in_ready  output  1  block accepts operands this cycle
in_a  input  WIDTH  multiplicand
in_b  input  WIDTH  multiplier
in_signed  input  1  1 = two's-complement operands, 0 = unsigned
in_tag  input  TAG_W  opaque tag, returned with the result
out_valid  output  1  result present
out_ready  input  1  consumer accepts result this cycle
out_product  output  2*WIDTH  product
out_tag  output  TAG_W  tag of this product

Behaviour:
- Reset (async assert, sync release): all stage-valid bits 0, so out_valid=0. out_product=0 and out_tag=0. in_ready=1 once rst deasserts. Data registers clear to 0.
- Stall rule: stall = out_valid & ~out_ready.
  - in_ready = ~stall. It is combinational from out_ready and must not depend on in_valid.
  - On stall, every stage register holds, bubbles included. No pipeline compression.
- Transfer:
  - An input is accepted when in_valid & in_ready.
  - An output is consumed when out_valid & out_ready.
  - Inputs and outputs may both transfer in the same cycle.
- S1 (capture): register in_a, in_b, in_signed, in_tag and a valid bit on accept. If in_valid=0 and no stall, load valid=0.
- S2 (reduce):
  - Generate WIDTH x WIDTH AND partial products from S1 registers.
  - Signed mode uses Baugh-Wooley: invert the MSB-row and MSB-column terms except a[W-1]&b[W-1], and add constant 1 at bits WIDTH and 2*WIDTH-1.
  - Unsigned mode uses plain AND terms with no constants.
  - Reduce by Wallace grouping: at each layer, every 3 bits in a column go to a FA and a leftover pair goes to a HA. Continue until every column holds at most 2 bits.
  - Register the sum row and carry row, each 2*WIDTH bits, plus tag and valid.
- S3 (resolve): out_product = sum_row + carry_row, truncated to 2*WIDTH bits. Register with tag and valid; this drives out_valid.
- Latency: exactly 3 cycles from the accept edge to out_valid with no stall. Each stall cycle adds exactly 1.
- Throughput: one result per cycle when out_ready is held 1.
- Ordering: results leave in acceptance order, and out_tag always matches the operands that produced out_product.
- Output stability: while out_valid=1 and out_ready=0, out_product and out_tag do not change.
- Arithmetic: the result is exact, with no overflow.
  - Unsigned: product = a*b in 0..(2^W-1)^2.
  - Signed: product = two's-complement a*b. The most negative operand squared (-2^(W-1))^2 = 2^(2W-2) fits.
- Mode is sampled per transaction, so a signed op may directly follow an unsigned op with no bubble.
- Reset mid-operation drops all in-flight results. No result is emitted after reset for operands accepted before reset.
- Zero operands and the mode bit never change latency.

Test Plan:
1. WIDTH=8, unsigned, a=0xFF, b=0xFF, out_ready=1 -> 3 cycles later out_valid=1, out_product=0xFE01, out_tag equals the input tag. in_ready stays 1.
2. Signed sweep, back-to-back over 4 consecutive cycles: (-128,-128), (-1,1), (127,-128), (0,-5) -> on consecutive cycles out_product = 0x4000, 0xFFFF, 0xC080, 0x0000, with no bubbles.
3. Mixed mode, back-to-back: unsigned 0x80*0x02 then signed 0x80*0x02 -> 0x0100 then 0xFF00, tags in order.
4. Backpressure: stream tags 0..7 with out_ready toggling 1,0,0,1,... -> in_ready equals ~(out_valid & ~out_ready) every cycle. No tag is lost or duplicated, and out_product is stable during stalls.
5. Reset mid-flight: accept 3 ops, assert rst for 1 cycle before any of them emerges -> out_valid=0 and out_product=0 during and after reset. The next op after release appears 3 cycles after its accept.
6. Random regression: for WIDTH=4, 8, 16, run 10k random operands with random mode, in_valid and out_ready -> every product matches a scoreboard model and the count of accepted inputs equals the count of consumed outputs.
